// File: rtl/data_memory_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// data_memory_arbiter_pkg
//   Shared definitions for the data memory arbiter:
//   - RISC-V funct3 width/sign codes for loads and stores
//   - arbiter FSM state and requester encodings
//   - default MMIO byte address
//   - sign/zero extension helpers used by the load formatter
// -----------------------------------------------------------------------------
package data_memory_arbiter_pkg;

    // Load width/sign codes
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store width codes
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [31:0] MMIO_ADDRESS_DEFAULT = 32'h0000_2000;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_READ_WAIT = 2'd1,
        ST_RESPOND   = 2'd2
    } arb_state_e;

    typedef enum logic {
        REQ_CORE   = 1'b0,
        REQ_LOADER = 1'b1
    } requester_e;

    function automatic logic [31:0] extend_byte(input logic [7:0] value, input logic is_signed);
        logic [31:0] result;
        if (is_signed) begin
            result = {{24{value[7]}}, value};
        end else begin
            result = {24'h00_0000, value};
        end
        return result;
    endfunction

    function automatic logic [31:0] extend_half(input logic [15:0] value, input logic is_signed);
        logic [31:0] result;
        if (is_signed) begin
            result = {{16{value[15]}}, value};
        end else begin
            result = {16'h0000, value};
        end
        return result;
    endfunction

endpackage

// File: rtl/data_memory_arbiter_load_store_formatter.sv
// -----------------------------------------------------------------------------
// data_memory_arbiter_load_store_formatter
//   Purely combinational byte-lane steering for the core port.
//   Ports:
//     is_store      in   1   1 = store decode, 0 = load decode
//     funct3        in   3   width/sign code
//     lane          in   2   byte offset inside the word (address[1:0])
//     store_data    in   32  raw store data (rs2)
//     load_word     in   32  raw memory word being loaded
//     write_strobe  out  4   byte-lane write strobes
//     write_data    out  32  lane-replicated store data
//     read_data     out  32  lane-selected, sign/zero extended load data
//     access_error  out  1   illegal funct3 or misaligned access
// -----------------------------------------------------------------------------
module data_memory_arbiter_load_store_formatter
    import data_memory_arbiter_pkg::*;
(
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [1:0]  lane,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic [3:0]  write_strobe,
    output logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        access_error
);

    logic [7:0]  lane_byte_s;
    logic [15:0] lane_half_s;

    // Pick the addressed byte and halfword out of the loaded word
    always_comb begin
        case (lane)
            2'd0:    lane_byte_s = load_word[7:0];
            2'd1:    lane_byte_s = load_word[15:8];
            2'd2:    lane_byte_s = load_word[23:16];
            2'd3:    lane_byte_s = load_word[31:24];
            default: lane_byte_s = load_word[7:0];
        endcase
        if (lane[1]) begin
            lane_half_s = load_word[31:16];
        end else begin
            lane_half_s = load_word[15:0];
        end
    end

    // Width decode: strobes and replicated data for stores, extension for loads
    always_comb begin
        write_strobe = 4'b0000;
        write_data   = 32'h0000_0000;
        read_data    = 32'h0000_0000;
        access_error = 1'b0;
        if (is_store) begin
            case (funct3)
                F3_SB: begin
                    write_strobe = 4'b0001 << lane;
                    write_data   = {4{store_data[7:0]}};
                end
                F3_SH: begin
                    if (lane[0]) begin
                        access_error = 1'b1;
                    end else begin
                        write_strobe = 4'b0011 << lane;
                        write_data   = {2{store_data[15:0]}};
                    end
                end
                F3_SW: begin
                    if (lane != 2'b00) begin
                        access_error = 1'b1;
                    end else begin
                        write_strobe = 4'b1111;
                        write_data   = store_data;
                    end
                end
                default: access_error = 1'b1;
            endcase
        end else begin
            case (funct3)
                F3_LB:  read_data = extend_byte(lane_byte_s, 1'b1);
                F3_LBU: read_data = extend_byte(lane_byte_s, 1'b0);
                F3_LH: begin
                    if (lane[0]) begin
                        access_error = 1'b1;
                    end else begin
                        read_data = extend_half(lane_half_s, 1'b1);
                    end
                end
                F3_LHU: begin
                    if (lane[0]) begin
                        access_error = 1'b1;
                    end else begin
                        read_data = extend_half(lane_half_s, 1'b0);
                    end
                end
                F3_LW: begin
                    if (lane != 2'b00) begin
                        access_error = 1'b1;
                    end else begin
                        read_data = load_word;
                    end
                end
                default: access_error = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/data_memory_arbiter.sv
// -----------------------------------------------------------------------------
// data_memory_arbiter
//   Shares one single-port word-organised data memory between the core
//   load/store stage (stall handshake) and the program loader
//   (request/ready handshake). Round-robin arbitration in IDLE, 3-cycle read
//   path (grant, wait, respond), single-cycle writes, alignment/funct3 error
//   retirement and one MMIO byte register.
//   Ports:
//     clk, reset_n                         clock, async active-low reset
//     core_request_read/_write             core load/store request
//     core_subfunction_3                   funct3 width/sign code
//     core_address, core_write_data        core byte address and store data
//     core_stall                           combinational pipeline hold
//     core_read_data                       formatted load result
//     core_decoding_error                  one-cycle error pulse
//     loader_request/_write/_address/_write_data   loader word access
//     loader_ready, loader_read_data       loader completion and read data
//     mem_address/_read_enable/_write_enable/_write_data/_read_data  memory
//     memory_mapped_io                     MMIO output byte
// -----------------------------------------------------------------------------
module data_memory_arbiter
    import data_memory_arbiter_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 12,
    parameter logic [31:0] MMIO_ADDRESS  = MMIO_ADDRESS_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     core_request_read,
    input  logic                     core_request_write,
    input  logic [2:0]               core_subfunction_3,
    input  logic [31:0]              core_address,
    input  logic [31:0]              core_write_data,
    output logic                     core_stall,
    output logic [31:0]              core_read_data,
    output logic                     core_decoding_error,
    input  logic                     loader_request,
    input  logic                     loader_write,
    input  logic [31:0]              loader_address,
    input  logic [31:0]              loader_write_data,
    output logic                     loader_ready,
    output logic [31:0]              loader_read_data,
    output logic [ADDRESS_WIDTH-3:0] mem_address,
    output logic                     mem_read_enable,
    output logic [3:0]               mem_write_enable,
    output logic [31:0]              mem_write_data,
    input  logic [31:0]              mem_read_data,
    output logic [7:0]               memory_mapped_io
);

    arb_state_e state_r;
    requester_e owner_r;
    requester_e last_grant_r;
    logic       mmio_read_r;

    logic        core_pending_s;
    logic        core_mmio_s;
    logic        grant_core_s;
    logic        grant_loader_s;
    logic        core_err_grant_s;
    logic        core_rd_grant_s;
    logic        core_wr_grant_s;
    logic [3:0]  fmt_strobe_s;
    logic [31:0] fmt_write_data_s;
    logic [31:0] fmt_read_data_s;
    logic        fmt_error_s;
    logic        unused_loader_bits_s;

    // Loader addresses are word-aligned and truncated; the dropped bits carry no meaning
    assign unused_loader_bits_s = ^{loader_address[31:ADDRESS_WIDTH], loader_address[1:0]};

    // A simultaneous read and write from the core is treated as a read
    assign core_pending_s = core_request_read | core_request_write;
    assign core_mmio_s    = (core_address == MMIO_ADDRESS);

    data_memory_arbiter_load_store_formatter u_formatter (
        .is_store     (~core_request_read),
        .funct3       (core_subfunction_3),
        .lane         (core_address[1:0]),
        .store_data   (core_write_data),
        .load_word    (mem_read_data),
        .write_strobe (fmt_strobe_s),
        .write_data   (fmt_write_data_s),
        .read_data    (fmt_read_data_s),
        .access_error (fmt_error_s)
    );

    // Round-robin grant, only in IDLE and never while reset is asserted
    always_comb begin
        grant_core_s   = 1'b0;
        grant_loader_s = 1'b0;
        if ((state_r == ST_IDLE) && reset_n && core_pending_s &&
            (!loader_request || (last_grant_r == REQ_LOADER))) begin
            grant_core_s = 1'b1;
        end else if ((state_r == ST_IDLE) && reset_n && loader_request) begin
            grant_loader_s = 1'b1;
        end else begin
            grant_core_s   = 1'b0;
            grant_loader_s = 1'b0;
        end
    end

    // An erroneous core request still consumes its grant but never touches memory
    assign core_err_grant_s = grant_core_s & fmt_error_s;
    assign core_rd_grant_s  = grant_core_s & ~fmt_error_s & core_request_read;
    assign core_wr_grant_s  = grant_core_s & ~fmt_error_s & ~core_request_read;

    // The core is released on a write grant, an error retirement or its RESPOND cycle
    assign core_stall = reset_n & core_pending_s &
                        ~(core_wr_grant_s | core_err_grant_s |
                          ((state_r == ST_RESPOND) && (owner_r == REQ_CORE)));

    // Memory strobes exist only in the granted IDLE cycle; MMIO accesses bypass memory
    always_comb begin
        mem_address      = '0;
        mem_read_enable  = 1'b0;
        mem_write_enable = 4'b0000;
        mem_write_data   = 32'h0000_0000;
        if (grant_loader_s) begin
            mem_address = loader_address[ADDRESS_WIDTH-1:2];
            if (loader_write) begin
                mem_write_enable = 4'b1111;
                mem_write_data   = loader_write_data;
            end else begin
                mem_read_enable = 1'b1;
            end
        end else if ((core_rd_grant_s || core_wr_grant_s) && !core_mmio_s) begin
            mem_address = core_address[ADDRESS_WIDTH-1:2];
            if (core_rd_grant_s) begin
                mem_read_enable = 1'b1;
            end else begin
                mem_write_enable = fmt_strobe_s;
                mem_write_data   = fmt_write_data_s;
            end
        end else begin
            mem_address      = '0;
            mem_read_enable  = 1'b0;
            mem_write_enable = 4'b0000;
            mem_write_data   = 32'h0000_0000;
        end
    end

    // Arbiter FSM with its registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r             <= ST_IDLE;
            owner_r             <= REQ_CORE;
            last_grant_r        <= REQ_LOADER;
            mmio_read_r         <= 1'b0;
            core_read_data      <= 32'h0000_0000;
            core_decoding_error <= 1'b0;
            loader_ready        <= 1'b0;
            loader_read_data    <= 32'h0000_0000;
            memory_mapped_io    <= 8'h00;
        end else begin
            core_decoding_error <= core_err_grant_s;
            loader_ready        <= 1'b0;
            if (grant_core_s) begin
                last_grant_r <= REQ_CORE;
            end else if (grant_loader_s) begin
                last_grant_r <= REQ_LOADER;
            end
            if (core_wr_grant_s && core_mmio_s) begin
                memory_mapped_io <= core_write_data[7:0];
            end
            case (state_r)
                ST_IDLE: begin
                    if (core_rd_grant_s) begin
                        state_r     <= ST_READ_WAIT;
                        owner_r     <= REQ_CORE;
                        mmio_read_r <= core_mmio_s;
                    end else if (grant_loader_s && !loader_write) begin
                        state_r     <= ST_READ_WAIT;
                        owner_r     <= REQ_LOADER;
                        mmio_read_r <= 1'b0;
                    end else if (grant_loader_s) begin
                        loader_ready <= 1'b1;
                    end
                end
                ST_READ_WAIT: begin
                    // Memory data is valid this cycle; core inputs are held by the stall
                    state_r <= ST_RESPOND;
                    if (owner_r == REQ_CORE) begin
                        if (mmio_read_r) begin
                            core_read_data <= {24'h00_0000, memory_mapped_io};
                        end else begin
                            core_read_data <= fmt_read_data_s;
                        end
                    end else begin
                        loader_read_data <= mem_read_data;
                        loader_ready     <= 1'b1;
                    end
                end
                ST_RESPOND: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_arbiter.sv
module tb_data_memory_arbiter;

    localparam logic [31:0] MMIO = 32'h0000_2000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        core_request_read, core_request_write;
    logic [2:0]  core_subfunction_3;
    logic [31:0] core_address, core_write_data;
    logic        core_stall;
    logic [31:0] core_read_data;
    logic        core_decoding_error;
    logic        loader_request, loader_write;
    logic [31:0] loader_address, loader_write_data;
    logic        loader_ready;
    logic [31:0] loader_read_data;
    logic [9:0]  mem_address;
    logic        mem_read_enable;
    logic [3:0]  mem_write_enable;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic [7:0]  memory_mapped_io;

    int cmp_cnt  = 0;
    int fail_cnt = 0;

    always #5 clk = ~clk;

    data_memory_arbiter dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .core_request_read   (core_request_read),
        .core_request_write  (core_request_write),
        .core_subfunction_3  (core_subfunction_3),
        .core_address        (core_address),
        .core_write_data     (core_write_data),
        .core_stall          (core_stall),
        .core_read_data      (core_read_data),
        .core_decoding_error (core_decoding_error),
        .loader_request      (loader_request),
        .loader_write        (loader_write),
        .loader_address      (loader_address),
        .loader_write_data   (loader_write_data),
        .loader_ready        (loader_ready),
        .loader_read_data    (loader_read_data),
        .mem_address         (mem_address),
        .mem_read_enable     (mem_read_enable),
        .mem_write_enable    (mem_write_enable),
        .mem_write_data      (mem_write_data),
        .mem_read_data       (mem_read_data),
        .memory_mapped_io    (memory_mapped_io)
    );

    // Behavioural single-port SRAM: registered read, byte-lane writes
    logic [31:0] sram [0:1023];
    logic        sram_clear;
    always @(posedge clk) begin
        if (sram_clear) begin
            for (int i = 0; i < 1024; i++) sram[i] <= 32'h0;
        end else begin
            if (mem_read_enable) mem_read_data <= sram[mem_address];
            for (int i = 0; i < 4; i++)
                if (mem_write_enable[i]) sram[mem_address][8*i +: 8] <= mem_write_data[8*i +: 8];
        end
    end

    // Reference model: little-endian byte array, MMIO byte, last core load result
    logic [7:0]  ref_mem [0:4095];
    logic [7:0]  ref_mmio;
    logic [31:0] ref_crd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic ref_err(input logic rd, input logic [2:0] f3, input logic [31:0] a);
        logic legal;
        int   sz;
        if (rd) legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        else    legal = (f3 <= 3'd2);
        sz = 1 << f3[1:0];
        return !legal || ((a % sz) != 0);
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
        int sz, idx;
        logic [31:0] v;
        if (a == MMIO) return {24'h0, ref_mmio};
        sz  = 1 << f3[1:0];
        idx = int'(a % 4096);
        v   = 32'h0;
        for (int b = 0; b < sz; b++) v = v | (32'(ref_mem[idx+b]) << (8*b));
        if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | ~((32'd1 << (8*sz)) - 32'd1);
        return v;
    endfunction

    task automatic ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        int sz, idx;
        if (a == MMIO) begin
            ref_mmio = d[7:0];
        end else begin
            sz  = 1 << f3[1:0];
            idx = int'(a % 4096);
            for (int b = 0; b < sz; b++) ref_mem[idx+b] = d[8*b +: 8];
        end
    endtask

    task automatic core_op(input logic rd, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] d, input string tag);
        logic e, mm, done, re0;
        logic [3:0] we0;
        logic [9:0] ad0;
        logic [31:0] rdv, exp_v;
        int stalls, sz, strobe;
        e  = ref_err(rd, f3, a);
        mm = (a == MMIO);
        @(posedge clk); #1;
        core_request_read = rd; core_request_write = !rd;
        core_subfunction_3 = f3; core_address = a; core_write_data = d;
        stalls = 0; done = 1'b0; rdv = 32'h0;
        @(negedge clk);
        re0 = mem_read_enable; we0 = mem_write_enable; ad0 = mem_address;
        for (int c = 0; c < 8 && !done; c++) begin
            if (c > 0) @(negedge clk);
            if (core_stall) stalls++;
            else begin done = 1'b1; rdv = core_read_data; end
        end
        @(posedge clk); #1;
        core_request_read = 1'b0; core_request_write = 1'b0;
        check({tag, "_done"}, 32'(done), 32'd1);
        if (e) begin
            check({tag, "_err_stalls"}, stalls, 0);
            check({tag, "_err_we"}, 32'(we0), 32'd0);
            check({tag, "_err_re"}, 32'(re0), 32'd0);
            @(negedge clk);
            check({tag, "_err_pulse"}, 32'(core_decoding_error), 32'd1);
            check({tag, "_err_rdata_kept"}, core_read_data, ref_crd);
            @(negedge clk);
            check({tag, "_err_pulse_end"}, 32'(core_decoding_error), 32'd0);
        end else if (rd) begin
            exp_v   = ref_load(f3, a);
            ref_crd = exp_v;
            check({tag, "_rd_stalls"}, stalls, 2);
            check({tag, "_rd_re"}, 32'(re0), 32'(!mm));
            check({tag, "_rd_we"}, 32'(we0), 32'd0);
            if (!mm) check({tag, "_rd_addr"}, 32'(ad0), 32'(a[11:2]));
            check({tag, "_rd_data"}, rdv, exp_v);
            @(negedge clk);
            check({tag, "_rd_no_err"}, 32'(core_decoding_error), 32'd0);
        end else begin
            sz     = 1 << f3[1:0];
            strobe = mm ? 0 : (((1 << sz) - 1) << (a % 4));
            check({tag, "_wr_stalls"}, stalls, 0);
            check({tag, "_wr_re"}, 32'(re0), 32'd0);
            check({tag, "_wr_we"}, 32'(we0), strobe);
            if (!mm) check({tag, "_wr_addr"}, 32'(ad0), 32'(a[11:2]));
            ref_store(f3, a, d);
            @(negedge clk);
            check({tag, "_wr_mmio"}, 32'(memory_mapped_io), 32'(ref_mmio));
            check({tag, "_wr_no_err"}, 32'(core_decoding_error), 32'd0);
        end
    endtask

    task automatic loader_op(input logic wr, input logic [31:0] a, input logic [31:0] d,
                             input string tag);
        int lat, base;
        logic done;
        logic [31:0] rdv, exp_v;
        @(posedge clk); #1;
        loader_request = 1'b1; loader_write = wr; loader_address = a; loader_write_data = d;
        lat = 0; done = 1'b0; rdv = 32'h0;
        for (int c = 0; c < 8 && !done; c++) begin
            @(negedge clk);
            lat++;
            if (loader_ready) begin done = 1'b1; rdv = loader_read_data; end
        end
        @(posedge clk); #1;
        loader_request = 1'b0;
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_latency"}, lat, wr ? 2 : 3);
        base = int'(a % 4096) & ~3;
        if (wr) begin
            for (int b = 0; b < 4; b++) ref_mem[base+b] = d[8*b +: 8];
        end else begin
            exp_v = 32'h0;
            for (int b = 0; b < 4; b++) exp_v = exp_v | (32'(ref_mem[base+b]) << (8*b));
            check({tag, "_rdata"}, rdv, exp_v);
        end
        repeat (2) @(posedge clk);
    endtask

    initial begin
        logic [31:0] a;
        int r;
        reset_n = 1'b1; sram_clear = 1'b1;
        core_request_read = 1'b0; core_request_write = 1'b0; core_subfunction_3 = 3'd0;
        core_address = 32'h0; core_write_data = 32'h0;
        loader_request = 1'b0; loader_write = 1'b0; loader_address = 32'h0; loader_write_data = 32'h0;
        for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;
        ref_mmio = 8'h00; ref_crd = 32'h0;
        #2 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 sram_clear = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_core_rdata", core_read_data, 32'h0);
        check("rst_loader_rdata", loader_read_data, 32'h0);
        check("rst_loader_ready", 32'(loader_ready), 32'd0);
        check("rst_dec_err", 32'(core_decoding_error), 32'd0);
        check("rst_mmio", 32'(memory_mapped_io), 32'd0);
        @(posedge clk); #1 reset_n = 1'b1;
        @(negedge clk);
        check("idle_stall", 32'(core_stall), 32'd0);
        check("idle_we", 32'(mem_write_enable), 32'd0);
        check("idle_re", 32'(mem_read_enable), 32'd0);

        // Directed word store/load
        core_op(1'b0, 3'b010, 32'h10, 32'hDEADBEEF, "sw_10");
        core_op(1'b1, 3'b010, 32'h10, 32'h0, "lw_10");
        check("lw_10_const", core_read_data, 32'hDEADBEEF);

        // Byte sign/zero extension, halfword store lanes
        core_op(1'b0, 3'b010, 32'h10, 32'h80FF0000, "sw_10b");
        core_op(1'b1, 3'b000, 32'h13, 32'h0, "lb_13");
        check("lb_13_const", core_read_data, 32'hFFFFFF80);
        core_op(1'b1, 3'b100, 32'h13, 32'h0, "lbu_13");
        check("lbu_13_const", core_read_data, 32'h00000080);
        core_op(1'b0, 3'b001, 32'h12, 32'h00001234, "sh_12");
        core_op(1'b1, 3'b010, 32'h10, 32'h0, "lw_10c");
        core_op(1'b1, 3'b001, 32'h12, 32'h0, "lh_12");

        // Misaligned word load
        core_op(1'b1, 3'b010, 32'h11, 32'h0, "lw_11_mis");

        // MMIO
        core_op(1'b0, 3'b000, MMIO, 32'h00000041, "sb_mmio");
        check("sb_mmio_const", 32'(memory_mapped_io), 32'h41);
        core_op(1'b1, 3'b100, MMIO, 32'h0, "lbu_mmio");
        check("lbu_mmio_const", core_read_data, 32'h41);

        // Loader word write and read
        loader_op(1'b1, 32'h24, 32'hCAFEF00D, "ld_wr_24");
        loader_op(1'b0, 32'h27, 32'h0, "ld_rd_24");

        // Reset asserted while a core read sits in READ_WAIT
        @(posedge clk); #1;
        core_request_read = 1'b1; core_subfunction_3 = 3'b010; core_address = 32'h10;
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        check("rstrw_core_rdata", core_read_data, 32'h0);
        check("rstrw_loader_rdata", loader_read_data, 32'h0);
        check("rstrw_mmio", 32'(memory_mapped_io), 32'd0);
        check("rstrw_re", 32'(mem_read_enable), 32'd0);
        check("rstrw_we", 32'(mem_write_enable), 32'd0);
        check("rstrw_stall", 32'(core_stall), 32'd0);
        ref_crd = 32'h0; ref_mmio = 8'h00;
        core_request_read = 1'b0;
        @(posedge clk); #1 reset_n = 1'b1;
        core_op(1'b1, 3'b010, 32'h10, 32'h0, "rd_after_rst");

        // Both requesters held continuously from reset: grants must alternate
        @(posedge clk); #1;
        reset_n = 1'b0;
        core_request_write = 1'b1; core_subfunction_3 = 3'b000; core_address = 32'h20;
        core_write_data = 32'h000000A5;
        loader_request = 1'b1; loader_write = 1'b1; loader_address = 32'h28;
        loader_write_data = 32'h11223344;
        @(negedge clk);
        check("rr_rst_we", 32'(mem_write_enable), 32'd0);
        @(posedge clk); #1 reset_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check($sformatf("rr_we_%0d", k), 32'(mem_write_enable), (k % 2 == 0) ? 32'h1 : 32'hF);
            check($sformatf("rr_stall_%0d", k), 32'(core_stall), 32'(k % 2));
            check($sformatf("rr_ready_%0d", k), 32'(loader_ready), 32'(k >= 2 && k % 2 == 0));
        end
        @(posedge clk); #1;
        core_request_write = 1'b0; loader_request = 1'b0;
        ref_crd = 32'h0; ref_mmio = 8'h00;
        ref_mem[32'h20] = 8'hA5;
        for (int b = 0; b < 4; b++) ref_mem[32'h28 + b] = loader_write_data[8*b +: 8];
        core_op(1'b1, 3'b100, 32'h20, 32'h0, "rr_chk_core");
        loader_op(1'b0, 32'h28, 32'h0, "rr_chk_loader");

        // Randomised mix against the reference model
        for (int n = 0; n < 50; n++) begin
            a = $urandom_range(0, 63);
            if ($urandom_range(0, 3) == 0) a = a | 32'h1000;
            if ($urandom_range(0, 9) == 0) a = MMIO;
            r = $urandom_range(0, 7);
            if (r < 2) loader_op(1'($urandom_range(0, 1)), a, $urandom, "rnd_ld");
            else core_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, "rnd_core");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
        $finish;
    end

endmodule
